dt_feeder: RTL and testbench

Host-side sequencer that sits directly upstream of the dynamic-tree array and drives its root. It accepts a batch of words on a valid/ready stream and issues one WRITE per word on `glob_com`/`tree_in`. It then issues one READ per stored word, captures the root output after the tree's command latency into a local buffer, and streams the results out with backpressure.

---
 rtl/dt_pkg.sv | 26 ++
 rtl/dt_result_fifo.sv | 58 +++++
 rtl/dt_feeder.sv | 214 +++++++++++++++++++++
 tb/tb_dt_feeder.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dt_pkg.sv
// Shared definitions for the dynamic-tree array and its host-side feeder:
// tree command encodings, feeder FSM states and default geometry.
package dt_pkg;

    // Default geometry of the attached tree.
    localparam int unsigned DefaultHbit      = 7;
    localparam int unsigned DefaultTreeLevel = 4;

    // Commands presented at the tree root; the fourth encoding is never driven.
    typedef enum logic [1:0] {
        CmdNoMessage = 2'd0,
        CmdWrite     = 2'd1,
        CmdRead      = 2'd2
    } dt_cmd_e;

    // Feeder sequencing states.
    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSettle,
        StRead,
        StCapture,
        StEmit
    } feeder_state_e;

endpackage

// File: rtl/dt_result_fifo.sv
// Result buffer for dt_feeder: single-cycle write, first-word-fall-through read.
// Storage is not reset; only the pointers are, which discards the contents.
module dt_result_fifo
    import dt_pkg::*;
#(
    parameter int unsigned Depth = 5,
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [Width-1:0] wr_data,
    input  logic             rd_en,
    output logic [Width-1:0] rd_data,
    output logic             empty
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_wr, do_rd;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_q == '0);
    assign do_wr   = wr_en && (count_q != FullCnt);
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q];

    // Data storage write port.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_rd) rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (do_wr && !do_rd) count_q <= count_q + 1'b1;
            else if (do_rd && !do_wr) count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/dt_feeder.sv
// Host-side sequencer for the dynamic-tree array: loads a batch with WRITEs,
// reads every word back through the root and streams the results out.
// Optional feature: define DT_FEEDER_STATS_EN to add the batch_cnt output.
module dt_feeder
    import dt_pkg::*;
#(
    parameter int unsigned HBIT       = DefaultHbit,
    parameter int unsigned TREE_LEVEL = DefaultTreeLevel,
    parameter int unsigned CAP        = TREE_LEVEL + 1,
    parameter int unsigned CMD_LAT    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [HBIT:0] in_data,
    input  logic          in_last,
    output logic [1:0]    glob_com,
    output logic [HBIT:0] tree_in,
    input  logic [HBIT:0] tree_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [HBIT:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          cap_hit
`ifdef DT_FEEDER_STATS_EN
    ,
    output logic [15:0]   batch_cnt
`endif
);

    if (CAP == 0 || CMD_LAT == 0) begin : g_param_check
        $error("dt_feeder: CAP and CMD_LAT must both be at least 1");
    end

    localparam int unsigned CntW = $clog2(CAP + 1);
    localparam int unsigned SetW = $clog2(CMD_LAT + 1);
    localparam logic [CntW-1:0] CapC     = CntW'(CAP);
    localparam logic [SetW-1:0] SettleLast = SetW'(CMD_LAT - 1);

    feeder_state_e state_q, state_d;
    dt_cmd_e       glob_com_q, glob_com_d;
    logic [HBIT:0] tree_in_q, tree_in_d, out_data_q, out_data_d;
    logic          in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d, cap_hit_q, cap_hit_d;
    logic [CntW-1:0] cnt_q, cnt_d, rd_cnt_q, rd_cnt_d;
    logic [CntW-1:0] cap_cnt_q, cap_cnt_d, emit_cnt_q, emit_cnt_d, cnt_inc;
    logic [SetW-1:0] settle_q, settle_d;
    // Bit k set means a READ launched k+1 edges ago is in flight.
    logic [CMD_LAT:0] vsr_q, vsr_d;
    logic          in_acc, fifo_wr, fifo_rd, fifo_empty;
    logic [HBIT:0] fifo_rdata;

    assign in_acc = in_valid && in_ready_q;

    dt_result_fifo #(
        .Depth (CAP),
        .Width (HBIT + 1)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fifo_wr),
        .wr_data (tree_out),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rdata),
        .empty   (fifo_empty)
    );

    // Next-state and registered-output computation.
    always_comb begin
        state_d    = state_q;
        glob_com_d = CmdNoMessage;
        tree_in_d  = tree_in_q;
        in_ready_d = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        cap_hit_d  = cap_hit_q;
        cnt_d      = cnt_q;
        rd_cnt_d   = rd_cnt_q;
        emit_cnt_d = emit_cnt_q;
        settle_d   = settle_q;
        cnt_inc    = cnt_q + 1'b1;
        vsr_d      = {vsr_q[CMD_LAT-1:0], 1'b0};
        fifo_wr    = vsr_q[CMD_LAT];
        fifo_rd    = 1'b0;
        cap_cnt_d  = fifo_wr ? cap_cnt_q + 1'b1 : cap_cnt_q;

        unique case (state_q)
            StIdle, StLoad: begin
                if (state_q == StIdle) in_ready_d = 1'b1;
                if (in_acc) begin
                    glob_com_d = CmdWrite;
                    tree_in_d  = in_data;
                    cnt_d      = cnt_inc;
                    if (state_q == StIdle) cap_hit_d = 1'b0;
                    if (in_last || cnt_inc == CapC) begin
                        state_d    = StSettle;
                        in_ready_d = 1'b0;
                        settle_d   = '0;
                        if (!in_last) cap_hit_d = 1'b1;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StSettle: begin
                if (settle_q == SettleLast) begin
                    state_d   = StRead;
                    rd_cnt_d  = '0;
                    cap_cnt_d = '0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            StRead: begin
                glob_com_d = CmdRead;
                tree_in_d  = '0;
                vsr_d[0]   = 1'b1;
                rd_cnt_d   = rd_cnt_q + 1'b1;
                if (rd_cnt_q + 1'b1 == cnt_q) state_d = StCapture;
            end
            StCapture: begin
                if (fifo_wr && (cap_cnt_q + 1'b1 == cnt_q)) begin
                    state_d    = StEmit;
                    emit_cnt_d = '0;
                end
            end
            StEmit: begin
                if (out_valid_q && out_ready && out_last_q) begin
                    state_d     = StIdle;
                    cnt_d       = '0;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end else if (!out_valid_q || out_ready) begin
                    // Refill the output register whenever it is empty or being taken.
                    if (emit_cnt_q != cnt_q && !fifo_empty) begin
                        fifo_rd     = 1'b1;
                        out_valid_d = 1'b1;
                        out_data_d  = fifo_rdata;
                        out_last_d  = (emit_cnt_q + 1'b1 == cnt_q);
                        emit_cnt_d  = emit_cnt_q + 1'b1;
                    end else begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            glob_com_q  <= CmdNoMessage;
            tree_in_q   <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            cap_hit_q   <= 1'b0;
            cnt_q       <= '0;
            rd_cnt_q    <= '0;
            cap_cnt_q   <= '0;
            emit_cnt_q  <= '0;
            settle_q    <= '0;
            vsr_q       <= '0;
        end else begin
            state_q     <= state_d;
            glob_com_q  <= glob_com_d;
            tree_in_q   <= tree_in_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            cap_hit_q   <= cap_hit_d;
            cnt_q       <= cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            cap_cnt_q   <= cap_cnt_d;
            emit_cnt_q  <= emit_cnt_d;
            settle_q    <= settle_d;
            vsr_q       <= vsr_d;
        end
    end

    assign glob_com  = glob_com_q;
    assign tree_in   = tree_in_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign cap_hit   = cap_hit_q;
    assign busy      = (state_q != StIdle);

`ifdef DT_FEEDER_STATS_EN
    logic [15:0] batch_cnt_q;

    // Completed-batch counter, wrapping naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            batch_cnt_q <= '0;
        end else if (out_valid_q && out_ready && out_last_q) begin
            batch_cnt_q <= batch_cnt_q + 16'd1;
        end
    end

    assign batch_cnt = batch_cnt_q;
`endif

endmodule

// File: tb/tb_dt_feeder.sv
// Self-checking bench for dt_feeder with a counter-driven tree stub.
module tb_dt_feeder;
    localparam int unsigned HBIT    = 7;
    localparam int unsigned CAP     = 5;
    localparam int          CMD_LAT = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       in_last = 1'b0;
    logic [1:0] glob_com;
    logic [7:0] tree_in, tree_out;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_last, busy, cap_hit;
`ifdef DT_FEEDER_STATS_EN
    logic [15:0] batch_cnt;
`endif

    int errors = 0;
    int checks = 0;

    dt_feeder #(
        .HBIT       (HBIT),
        .TREE_LEVEL (4),
        .CAP        (CAP),
        .CMD_LAT    (CMD_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .glob_com  (glob_com),
        .tree_in   (tree_in),
        .tree_out  (tree_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .cap_hit   (cap_hit)
`ifdef DT_FEEDER_STATS_EN
        ,
        .batch_cnt (batch_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Tree stub: root output is the number of the most recent clock edge.
    int unsigned edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;
    assign tree_out = edge_n[7:0];

    // Observation logs, sampled mid-cycle.
    logic [7:0]  wr_log[$];
    int unsigned rd_log[$];
    logic [8:0]  res_log[$];
    logic [1:0]  com_seq[$];
    int          bad_com = 0;
    int          stall_viol = 0;
    logic        stall_pend = 1'b0;
    logic [8:0]  stall_val = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            com_seq.push_back(glob_com);
            if (glob_com == 2'd1) wr_log.push_back(tree_in);
            if (glob_com == 2'd2) rd_log.push_back(edge_n);
            if (glob_com == 2'd3) bad_com <= bad_com + 1;
            if (out_valid && out_ready) res_log.push_back({out_last, out_data});
            if (stall_pend && (!out_valid || {out_last, out_data} !== stall_val))
                stall_viol <= stall_viol + 1;
            stall_pend <= out_valid && !out_ready;
            stall_val  <= {out_last, out_data};
        end else begin
            stall_pend <= 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    logic [7:0] stim [8];
    int acc_n;
    bit timed_out;
    logic ready_after_acc;

    // Offer stim[0..n-1], then drain the results with the chosen out_ready policy.
    task automatic run_batch(input int n, input bit use_last, input int gap_max,
                             input int rdy_mode);
        int  budget;
        bit  got;
        acc_n = 0;
        timed_out = 1'b0;
        wr_log.delete(); rd_log.delete(); res_log.delete(); com_seq.delete();
        for (int i = 0; i < n; i++) begin
            int g;
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (g) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = stim[i];
            in_last  = use_last && (i == n - 1);
            got = 1'b0;
            budget = 0;
            while (!got && budget < 8) begin
                @(negedge clk);
                got = in_ready;
                @(posedge clk); #1;
                budget++;
            end
            if (!got) break;
            acc_n++;
            ready_after_acc = in_ready;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        budget = 0;
        while ((busy || res_log.size() < acc_n) && budget < 200) begin
            case (rdy_mode)
                1: out_ready = 1'($urandom_range(1, 0));
                2: out_ready = (budget % 4 == 0) || (budget % 4 == 3);
                default: out_ready = 1'b1;
            endcase
            @(posedge clk); #1;
            budget++;
        end
        out_ready = 1'b1;
        timed_out = (budget >= 200);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({glob_com, tree_in, in_ready, out_valid, out_data, out_last, busy, cap_hit} !== '0)
        begin
            errors++;
            $display("FAIL reset_outputs: got com=%0d tree_in=%h in_ready=%b ov=%b od=%h ol=%b busy=%b cap=%b, want all 0",
                     glob_com, tree_in, in_ready, out_valid, out_data, out_last, busy, cap_hit);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready: got %b want 1", in_ready);
        end
    endtask

    // No-stall batch: WRITE per word, CMD_LAT idles, READ per word, results from the stub.
    task automatic test_timing(input string name, input int n, input bit fixed_words);
        int first;
        int len;
        logic [1:0] exp_c;
        for (int i = 0; i < n; i++)
            stim[i] = fixed_words ? 8'((i + 1) * 17) : 8'($urandom);
        run_batch(n, 1'b1, 0, 0);
        checks++;
        if (timed_out || acc_n != n) begin
            errors++;
            $display("FAIL %s_complete: accepted=%0d timeout=%0d want accepted=%0d timeout=0",
                     name, acc_n, timed_out, n);
        end
        first = -1;
        foreach (com_seq[i]) if (first < 0 && com_seq[i] == 2'd1) first = i;
        len = 2 * n + CMD_LAT + 1;
        checks++;
        if (first < 0 || first + len > com_seq.size()) begin
            errors++;
            $display("FAIL %s_cmd_window: first_write=%0d log=%0d want a %0d-cycle window",
                     name, first, com_seq.size(), len);
        end else begin
            for (int k = 0; k < len; k++) begin
                if (k < n) exp_c = 2'd1;
                else if (k < n + CMD_LAT) exp_c = 2'd0;
                else if (k < 2 * n + CMD_LAT) exp_c = 2'd2;
                else exp_c = 2'd0;
                checks++;
                if (com_seq[first + k] !== exp_c) begin
                    errors++;
                    $display("FAIL %s_cmd[%0d]: got %0d want %0d", name, k, com_seq[first + k],
                             exp_c);
                end
            end
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (i >= wr_log.size() || wr_log[i] !== stim[i]) begin
                errors++;
                $display("FAIL %s_write[%0d]: got %h want %h", name, i,
                         (i < wr_log.size()) ? wr_log[i] : 8'hxx, stim[i]);
            end
        end
        checks++;
        if (res_log.size() != n || rd_log.size() != n) begin
            errors++;
            $display("FAIL %s_counts: results=%0d reads=%0d want %0d", name, res_log.size(),
                     rd_log.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if (res_log[i] !== {i == n - 1, 8'(rd_log[i] + CMD_LAT)}) begin
                    errors++;
                    $display("FAIL %s_result[%0d]: got last=%b data=%h want last=%b data=%h",
                             name, i, res_log[i][8], res_log[i][7:0], i == n - 1,
                             8'(rd_log[i] + CMD_LAT));
                end
            end
        end
        checks++;
        if (cap_hit !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_flags: cap_hit=%b busy=%b want 0 0", name, cap_hit, busy);
        end
    endtask

    task automatic test_cap_limit();
        for (int i = 0; i < 6; i++) stim[i] = 8'($urandom);
        run_batch(6, 1'b0, 0, 0);
        checks++;
        if (acc_n != CAP || timed_out) begin
            errors++;
            $display("FAIL cap_accepted: got %0d timeout=%0d want %0d", acc_n, timed_out, CAP);
        end
        checks++;
        if (ready_after_acc !== 1'b0) begin
            errors++;
            $display("FAIL cap_ready_drop: got %b want 0", ready_after_acc);
        end
        checks++;
        if (cap_hit !== 1'b1) begin
            errors++;
            $display("FAIL cap_hit_set: got %b want 1", cap_hit);
        end
        checks++;
        if (res_log.size() != CAP || rd_log.size() != CAP) begin
            errors++;
            $display("FAIL cap_results: results=%0d reads=%0d want %0d", res_log.size(),
                     rd_log.size(), CAP);
        end else begin
            for (int i = 0; i < CAP; i++) begin
                checks++;
                if (res_log[i] !== {i == CAP - 1, 8'(rd_log[i] + CMD_LAT)} ||
                    wr_log[i] !== stim[i]) begin
                    errors++;
                    $display("FAIL cap_word[%0d]: got res=%h wr=%h want res=%h wr=%h", i,
                             res_log[i], wr_log[i], {i == CAP - 1, 8'(rd_log[i] + CMD_LAT)},
                             stim[i]);
                end
            end
        end
        stim[0] = 8'hA5;
        stim[1] = 8'h5A;
        run_batch(2, 1'b1, 0, 0);
        checks++;
        if (cap_hit !== 1'b0 || res_log.size() != 2) begin
            errors++;
            $display("FAIL cap_hit_clear: got cap_hit=%b results=%0d want 0 and 2", cap_hit,
                     res_log.size());
        end
    endtask

    task automatic test_backpressure();
        int viol0;
        viol0 = stall_viol;
        for (int i = 0; i < 4; i++) stim[i] = 8'($urandom);
        run_batch(4, 1'b1, 0, 2);
        checks++;
        if (stall_viol != viol0) begin
            errors++;
            $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_viol - viol0);
        end
        checks++;
        if (timed_out || res_log.size() != 4 || rd_log.size() != 4) begin
            errors++;
            $display("FAIL bp_count: results=%0d timeout=%0d want 4 and 0", res_log.size(),
                     timed_out);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (res_log[i] !== {i == 3, 8'(rd_log[i] + CMD_LAT)}) begin
                    errors++;
                    $display("FAIL bp_result[%0d]: got %h want %h", i, res_log[i],
                             {i == 3, 8'(rd_log[i] + CMD_LAT)});
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_ready: got %b want 1", in_ready);
        end
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'($urandom);
            in_last = (i == 2);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (glob_com == 2'd2) seen = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL mid_read_reached: got no READ want READ within 20 cycles");
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({glob_com, tree_in, in_ready, out_valid, out_data, out_last, busy, cap_hit} !== '0)
        begin
            errors++;
            $display("FAIL mid_async_reset: got com=%0d tree_in=%h ov=%b busy=%b want all 0",
                     glob_com, tree_in, out_valid, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_gaps();
        int first;
        int last;
        int stray;
        for (int i = 0; i < 4; i++) stim[i] = 8'($urandom);
        run_batch(4, 1'b1, 3, 1);
        first = -1;
        last  = -1;
        foreach (com_seq[i]) if (com_seq[i] == 2'd1) begin
            if (first < 0) first = i;
            last = i;
        end
        stray = 0;
        if (first >= 0)
            for (int i = first; i <= last; i++)
                if (com_seq[i] != 2'd1 && com_seq[i] != 2'd0) stray++;
        checks++;
        if (stray != 0 || first < 0) begin
            errors++;
            $display("FAIL gap_idle_cmds: got %0d non-NOMESSAGE idles (first=%0d) want 0",
                     stray, first);
        end
        checks++;
        if (wr_log.size() != acc_n || acc_n != 4) begin
            errors++;
            $display("FAIL gap_write_count: got writes=%0d accepted=%0d want 4 and 4",
                     wr_log.size(), acc_n);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_log[i] !== stim[i]) begin
                    errors++;
                    $display("FAIL gap_write[%0d]: got %h want %h", i, wr_log[i], stim[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int b = 0; b < 4; b++) begin
            int n;
            n = int'($urandom_range(CAP, 1));
            for (int i = 0; i < n; i++) stim[i] = 8'($urandom);
            run_batch(n, 1'b1, 2, 1);
            checks++;
            if (timed_out || acc_n != n || res_log.size() != n || rd_log.size() != n) begin
                errors++;
                $display("FAIL rand%0d_count: acc=%0d results=%0d reads=%0d timeout=%0d want %0d",
                         b, acc_n, res_log.size(), rd_log.size(), timed_out, n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    checks++;
                    if (res_log[i] !== {i == n - 1, 8'(rd_log[i] + CMD_LAT)} ||
                        wr_log[i] !== stim[i]) begin
                        errors++;
                        $display("FAIL rand%0d_word[%0d]: got res=%h wr=%h want res=%h wr=%h", b,
                                 i, res_log[i], wr_log[i], {i == n - 1, 8'(rd_log[i] + CMD_LAT)},
                                 stim[i]);
                    end
                end
            end
        end
    endtask

`ifdef DT_FEEDER_STATS_EN
    task automatic test_stats();
        logic [15:0] before;
        before = batch_cnt;
        stim[0] = 8'h3C;
        stim[1] = 8'hC3;
        run_batch(2, 1'b1, 0, 0);
        checks++;
        if (batch_cnt !== before + 16'd1) begin
            errors++;
            $display("FAIL stats_incr: got %h want %h", batch_cnt, before + 16'd1);
        end
        force dut.batch_cnt_q = 16'hFFFF;
        @(posedge clk); #1;
        release dut.batch_cnt_q;
        run_batch(1, 1'b1, 0, 0);
        checks++;
        if (batch_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL stats_wrap: got %h want 0000", batch_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_timing("basic", 3, 1'b1);
        test_cap_limit();
        test_backpressure();
        test_reset_mid();
        test_timing("after_reset", 3, 1'b1);
        test_gaps();
        test_random();
        test_timing("single", 1, 1'b0);
`ifdef DT_FEEDER_STATS_EN
        test_stats();
`endif
        checks++;
        if (bad_com != 0) begin
            errors++;
            $display("FAIL cmd_encoding: got %0d cycles with command 3 want 0", bad_com);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
